// File: rtl/frame_capture_sched_if.sv
// Valid/ready stream carrying captured sample words from the frame
// scheduler to the PS-side DMA.
interface frame_capture_sched_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] m_tdata_o;
  logic                  m_tvalid_o;
  logic                  m_tready_i;
  logic                  m_tlast_o;

  modport master (
    output m_tdata_o,
    output m_tvalid_o,
    output m_tlast_o,
    input  m_tready_i
  );

  modport slave (
    input  m_tdata_o,
    input  m_tvalid_o,
    input  m_tlast_o,
    output m_tready_i
  );
endinterface

// File: rtl/frame_capture_sched.sv
// Captures one decimated frame of PDH sample words into a 1-deep output
// register and streams it out, with abort, overrun and completion status.
module frame_capture_sched #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEC_WIDTH   = 26,
  parameter int FRAME_BEATS = 2048,
  parameter int CNT_WIDTH   = $clog2(FRAME_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DEC_WIDTH-1:0]  decimation_code_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  frame_capture_sched_if.master m_axis,
  output logic                  engaged_o,
  output logic                  finished_o,
  output logic                  overrun_o,
  output logic [CNT_WIDTH-1:0]  beat_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LP_BEATS = CNT_WIDTH'(FRAME_BEATS);
  localparam logic [CNT_WIDTH-1:0] LP_LAST  = CNT_WIDTH'(FRAME_BEATS - 1);

  state_t                r_state;
  logic [DEC_WIDTH-1:0]  r_n;
  logic [DEC_WIDTH-1:0]  r_dec_cnt;
  logic [CNT_WIDTH-1:0]  r_cap_cnt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_engaged;
  logic                  r_finished;
  logic                  r_overrun;
  logic                  r_aborted;

  logic w_hs;
  logic w_strobe;
  logic w_load;

  assign w_hs     = r_tvalid & m_axis.m_tready_i;
  assign w_strobe = (r_state == S_CAPTURE) & enable_i & (r_dec_cnt == {DEC_WIDTH{1'b0}});
  // A strobe can reuse the register in the same cycle its word is accepted.
  assign w_load   = w_strobe & (~r_tvalid | w_hs);

  // Frame sequencer, output register and status flags.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_n        <= {DEC_WIDTH{1'b0}};
      r_dec_cnt  <= {DEC_WIDTH{1'b0}};
      r_cap_cnt  <= {CNT_WIDTH{1'b0}};
      r_beat_cnt <= {CNT_WIDTH{1'b0}};
      r_tdata    <= {DATA_WIDTH{1'b0}};
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_engaged  <= 1'b0;
      r_finished <= 1'b0;
      r_overrun  <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        if (r_beat_cnt != LP_BEATS) begin
          r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          r_engaged  <= 1'b0;
          r_finished <= 1'b0;
          r_aborted  <= 1'b0;
          if (enable_i) begin
            r_state    <= S_CAPTURE;
            r_engaged  <= 1'b1;
            r_n        <= (decimation_code_i == {DEC_WIDTH{1'b0}}) ? DEC_WIDTH'(1)
                                                                   : decimation_code_i;
            r_dec_cnt  <= {DEC_WIDTH{1'b0}};
            r_cap_cnt  <= {CNT_WIDTH{1'b0}};
            r_beat_cnt <= {CNT_WIDTH{1'b0}};
            r_overrun  <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (enable_i) begin
            r_dec_cnt <= (r_dec_cnt == r_n - DEC_WIDTH'(1)) ? {DEC_WIDTH{1'b0}}
                                                            : r_dec_cnt + DEC_WIDTH'(1);
            if (w_load) begin
              r_tdata   <= sample_i;
              r_tvalid  <= 1'b1;
              r_tlast   <= (r_cap_cnt == LP_LAST);
              r_cap_cnt <= r_cap_cnt + CNT_WIDTH'(1);
              if (r_cap_cnt == LP_LAST) begin
                r_state <= S_DRAIN;
              end
            end else if (w_strobe) begin
              r_overrun <= 1'b1;
            end
          end else if (!r_tvalid || w_hs) begin
            r_state   <= S_IDLE;
            r_engaged <= 1'b0;
          end else begin
            // Abort with a word still pending: close the partial frame on it.
            r_tlast   <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            r_engaged <= 1'b0;
            if (r_aborted) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_DONE;
              r_finished <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!enable_i) begin
            r_state    <= S_IDLE;
            r_finished <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis.m_tdata_o  = r_tdata;
  assign m_axis.m_tvalid_o = r_tvalid;
  assign m_axis.m_tlast_o  = r_tlast;
  assign engaged_o         = r_engaged;
  assign finished_o        = r_finished;
  assign overrun_o         = r_overrun;
  assign beat_count_o      = r_beat_cnt;

endmodule

// File: tb/tb_frame_capture_sched.sv
// Scoreboard bench for frame_capture_sched with an 8-beat frame: expected
// words are queued when a frame is started and popped on each handshake.
module tb_frame_capture_sched;

  localparam int DW   = 64;
  localparam int DECW = 26;
  localparam int FB   = 8;
  localparam int CW   = $clog2(FB + 1);
  localparam int SW   = DW + 1;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            enable_i;
  logic [DECW-1:0] dec_code;
  logic [DW-1:0]   sample_i;
  logic            engaged_o;
  logic            finished_o;
  logic            overrun_o;
  logic [CW-1:0]   beat_count_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc      = 0;
  logic [DW:0] sb_q[$];

  frame_capture_sched_if #(.DATA_WIDTH(DW)) u_if ();

  frame_capture_sched #(
    .DATA_WIDTH (DW),
    .DEC_WIDTH  (DECW),
    .FRAME_BEATS(FB),
    .CNT_WIDTH  (CW)
  ) u_dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .decimation_code_i(dec_code),
    .sample_i         (sample_i),
    .m_axis           (u_if),
    .engaged_o        (engaged_o),
    .finished_o       (finished_o),
    .overrun_o        (overrun_o),
    .beat_count_o     (beat_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] samp(input int unsigned c);
    return {~c, c};
  endfunction

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample_i = samp(cyc);
  endtask

  // Raise enable now: first strobe samples the next cycle's word.
  task automatic start_frame(input logic [DECW-1:0] code, input int n_eff);
    dec_code = code;
    enable_i = 1'b1;
    for (int k = 0; k < FB; k++) begin
      sb_q.push_back({(k == FB - 1), samp(cyc + 1 + k * n_eff)});
    end
  endtask

  task automatic wait_done(input string tag, input bit chk_eng);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (finished_o) break;
      if (chk_eng) chk({tag, "_engaged"}, SW'(engaged_o), SW'(1));
    end
    chk({tag, "_finished"}, SW'(finished_o), SW'(1));
  endtask

  task automatic finish_frame(input string tag, input logic exp_ovr);
    chk({tag, "_beats"}, SW'(beat_count_o), SW'(FB));
    chk({tag, "_overrun"}, SW'(overrun_o), SW'(exp_ovr));
    chk({tag, "_sb_left"}, SW'(sb_q.size()), SW'(0));
    chk({tag, "_tvalid_off"}, SW'(u_if.m_tvalid_o), SW'(0));
    enable_i = 1'b0;
    tick();
    tick();
    chk({tag, "_finished_clr"}, SW'(finished_o), SW'(0));
    chk({tag, "_engaged_clr"}, SW'(engaged_o), SW'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, SW'(u_if.m_tvalid_o), SW'(0));
    chk({tag, "_tlast"}, SW'(u_if.m_tlast_o), SW'(0));
    chk({tag, "_tdata"}, SW'(u_if.m_tdata_o), SW'(0));
    chk({tag, "_engaged"}, SW'(engaged_o), SW'(0));
    chk({tag, "_finished"}, SW'(finished_o), SW'(0));
    chk({tag, "_overrun"}, SW'(overrun_o), SW'(0));
    chk({tag, "_beats"}, SW'(beat_count_o), SW'(0));
  endtask

  // Handshake monitor and stall-stability checker.
  initial begin
    logic          pv, pr, pen, pl;
    logic [DW-1:0] pd;
    logic [DW:0]   exp_w;
    pv = 1'b0; pr = 1'b0; pen = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("stall_valid", SW'(u_if.m_tvalid_o), SW'(1));
          chk("stall_data", SW'(u_if.m_tdata_o), SW'(pd));
          if (pen) chk("stall_last", SW'(u_if.m_tlast_o), SW'(pl));
        end
        if (u_if.m_tvalid_o && u_if.m_tready_i) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected", SW'(sb_q.size() + 1), SW'(0));
          end else begin
            exp_w = sb_q.pop_front();
            chk("beat", {u_if.m_tlast_o, u_if.m_tdata_o}, exp_w);
          end
        end
        pv  = u_if.m_tvalid_o;
        pr  = u_if.m_tready_i;
        pd  = u_if.m_tdata_o;
        pl  = u_if.m_tlast_o;
        pen = enable_i;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e;
    rst_i           = 1'b1;
    enable_i        = 1'b0;
    dec_code        = DECW'(1);
    sample_i        = samp(0);
    u_if.m_tready_i = 1'b1;
    tick();
    tick();
    chk_zero("rst");
    rst_i = 1'b0;
    tick();
    chk_zero("idle");

    // Contiguous frame, N=1.
    start_frame(DECW'(1), 1);
    wait_done("n1", 1'b1);
    finish_frame("n1", 1'b0);

    // N=4; a mid-frame code change must not take effect.
    start_frame(DECW'(4), 4);
    repeat (5) tick();
    dec_code = DECW'(2);
    wait_done("n4", 1'b1);
    finish_frame("n4", 1'b0);

    // Backpressure: ready low for 10 cycles after the first beat.
    e        = cyc;
    dec_code = DECW'(1);
    enable_i = 1'b1;
    sb_q.push_back({1'b0, samp(e + 1)});
    sb_q.push_back({1'b0, samp(e + 2)});
    for (int k = 13; k <= 18; k++) sb_q.push_back({(k == 18), samp(e + k)});
    repeat (3) tick();
    u_if.m_tready_i = 1'b0;
    repeat (10) tick();
    u_if.m_tready_i = 1'b1;
    wait_done("bp", 1'b1);
    finish_frame("bp", 1'b1);

    // Code 0 behaves as N=1.
    start_frame(DECW'(0), 1);
    wait_done("n0", 1'b1);
    finish_frame("n0", 1'b0);

    // Abort after beat 3 with word 4 pending.
    e        = cyc;
    dec_code = DECW'(1);
    enable_i = 1'b1;
    for (int k = 1; k <= 4; k++) sb_q.push_back({(k == 4), samp(e + k)});
    repeat (5) tick();
    chk("ab_beats3", SW'(beat_count_o), SW'(3));
    u_if.m_tready_i = 1'b0;
    enable_i        = 1'b0;
    tick();
    chk("ab_tlast_forced", SW'(u_if.m_tlast_o), SW'(1));
    u_if.m_tready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!engaged_o) break;
    end
    chk("ab_engaged", SW'(engaged_o), SW'(0));
    chk("ab_beats4", SW'(beat_count_o), SW'(4));
    chk("ab_sb_left", SW'(sb_q.size()), SW'(0));
    tick();
    chk("ab_finished", SW'(finished_o), SW'(0));
    chk("ab_tvalid", SW'(u_if.m_tvalid_o), SW'(0));

    // Re-enable starts a fresh frame with counters cleared.
    start_frame(DECW'(1), 1);
    tick();
    chk("re_beats0", SW'(beat_count_o), SW'(0));
    chk("re_engaged", SW'(engaged_o), SW'(1));
    wait_done("re", 1'b1);
    finish_frame("re", 1'b0);

    // Asynchronous reset mid-capture.
    start_frame(DECW'(1), 1);
    repeat (4) tick();
    #2;
    rst_i = 1'b1;
    #1;
    chk_zero("mrst");
    enable_i = 1'b0;
    sb_q.delete();
    tick();
    rst_i = 1'b0;
    tick();
    start_frame(DECW'(1), 1);
    wait_done("post_rst", 1'b1);
    finish_frame("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_sched.md
Name: frame_capture_sched

Overview:
Sequences one DMA frame capture of the 64-bit PDH sample word {i_feed, q_feed, cos_theta, sin_theta} from the core into the PS-side DMA stream. On enable it decimates the per-clock sample stream by the programmed code and presents exactly FRAME_BEATS words on a valid/ready master interface, asserting last on the final word. It reports engaged/finished status back to the core's GPIO callback path and flags any samples dropped under backpressure.

Parameters:
DATA_WIDTH, 64, sample/stream word width
DEC_WIDTH, 26, decimation code width
FRAME_BEATS, 2048, words per frame (>=2)
CNT_WIDTH, $clog2(FRAME_BEATS+1), beat counter width

Ports:
clk  in  1  system clock
rst_i  in  1  reset; asynchronous, active-high
enable_i  in  1  capture request, level (core's dma_enable)
decimation_code_i  in  DEC_WIDTH  take 1 sample every N clocks; 0 treated as 1
sample_i  in  DATA_WIDTH  sample word, new value every clk
m_tdata_o  out  DATA_WIDTH  stream data
m_tvalid_o  out  1  stream valid
m_tready_i  in  1  stream ready from DMA
m_tlast_o  out  1  final word of frame
engaged_o  out  1  capture in progress
finished_o  out  1  frame completed, held until enable_i low
overrun_o  out  1  sticky: >=1 decimated sample dropped this frame
beat_count_o  out  CNT_WIDTH  words handshaken this frame

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; m_tdata_o 0.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE: engaged_o=0. enable_i=1 -> CAPTURE; latch N=max(decimation_code_i,1); clear overrun_o, beat_count_o, capture count, dec_cnt=0. decimation_code_i changes outside IDLE are ignored.
- CAPTURE: engaged_o=1. Capture strobe when dec_cnt==0; dec_cnt counts 0..N-1 and wraps. First strobe on first CAPTURE cycle.
- Output register is 1 deep. On strobe: if register empty, or occupied and handshaking this cycle (m_tvalid_o&m_tready_i), load sample_i; m_tvalid_o=1 next cycle. Latency: sample_i at strobe cycle k appears on m_tdata_o in cycle k+1.
- Strobe with register occupied and not handshaking: sample dropped, overrun_o<=1, capture count not incremented; decimation phase unchanged.
- While m_tvalid_o=1 and m_tready_i=0: m_tdata_o, m_tlast_o stable (no change until handshake).
- m_tlast_o=1 exactly on the word loaded as capture number FRAME_BEATS. After that load -> DRAIN; no further strobes.
- beat_count_o increments on each handshake; saturates at FRAME_BEATS.
- DRAIN: engaged_o=1; on handshake of last word -> DONE (m_tvalid_o, m_tlast_o deassert same edge).
- DONE: engaged_o=0, finished_o=1; enable_i=0 -> IDLE, finished_o=0 next cycle. enable_i held high does not restart.
- Abort: enable_i=0 in CAPTURE: no new strobes; if register empty -> IDLE immediately; else force m_tlast_o=1 on pending word, go DRAIN, on its handshake -> IDLE (not DONE); finished_o stays 0. enable_i=0 in DRAIN for a full frame: completes normally to DONE then IDLE next cycle.
- enable_i re-asserted in DRAIN after abort: ignored until IDLE.
- rst_i mid-frame: immediate return to reset values; partial frame discarded, no tlast issued.

Test Plan:
- FRAME_BEATS=8, N=1, ready=1, sample_i=cycle counter c0.. -> 8 contiguous beats data c0..c7, tlast only on beat 8, finished_o=1 cycle after, beat_count_o=8, overrun_o=0.
- N=4, ready=1 -> beats every 4th cycle, data c0,c4,...,c28; engaged_o high throughout; decimation_code_i changed to 2 mid-frame has no effect.
- N=1, ready low 10 cycles after first beat -> tdata/tlast stable, overrun_o=1, frame still exactly 8 beats with tlast on 8th.
- decimation_code_i=0 -> identical to N=1 case.
- enable_i dropped after beat 3 with word pending -> pending word has tlast=1, return to IDLE, finished_o=0, beat_count_o=4; re-enable starts fresh frame with counters cleared.
- rst_i pulsed mid-CAPTURE -> all outputs 0 asynchronously; next enable_i yields full clean 8-beat frame.
